// File: rtl/adder_tree_sched.sv
// adder_tree_sched
// ----------------
// Round-robin scheduler that lets N_REQ requesters share one
// augmented_adder_tree. Each transaction goes through the following steps:
// - Arbitrate among the active requests, scanning upward from ptr.
// - Launch the winner's operand vector with a one-cycle tree_start.
// - Wait for tree_done.
// - Return the sum to the winner with a one-cycle rsp_valid strobe.
// If the tree never answers within TIMEOUT cycles, the scheduler pulses
// tree_rst_n low, returns a zero sum and sets the sticky err_timeout flag.
//
// Ports:
//   clk          single rising-edge clock
//   rst          synchronous active-high reset
//   req          per-requester request, held until its rsp_valid
//   req_data     operand vectors, requester r at [r*INPUTS_NUM*WIDTH +: INPUTS_NUM*WIDTH]
//   gnt          one-hot grant, LAUNCH through RESP
//   rsp_valid    one-hot single-cycle result strobe
//   rsp_sum      registered result, valid with rsp_valid
//   tree_start   one-cycle launch pulse to the tree
//   tree_data    granted operand vector to the tree (muxed from registered g)
//   tree_sum     sum from the tree
//   tree_done    completion from the tree (honoured only while waiting)
//   tree_rst_n   registered active-low reset to the tree
//   busy         high whenever the scheduler is not idle
//   err_timeout  sticky hang indication, cleared only by rst
module adder_tree_sched #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned INPUTS_NUM = 8,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned STAGES    = $clog2(INPUTS_NUM),
  localparam int unsigned SUM_W     = WIDTH + STAGES,
  localparam int unsigned PTR_W     = $clog2(N_REQ),
  localparam int unsigned VEC_W     = INPUTS_NUM * WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*VEC_W-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [SUM_W-1:0]       rsp_sum,
  output logic                   tree_start,
  output logic [VEC_W-1:0]       tree_data,
  input  logic [SUM_W-1:0]       tree_sum,
  input  logic                   tree_done,
  output logic                   tree_rst_n,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FLUSH,
    RESP
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] g_q;
  logic [WD_W-1:0]  wd_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [SUM_W-1:0] rsp_sum_q;
  logic             tree_start_q;
  logic             tree_rst_n_q;
  logic             busy_q;
  logic             err_q;

  // Round-robin pick: first set request bit at or above ptr, wrapping.
  logic [PTR_W-1:0] sel_d;
  logic             found_d;
  int unsigned      idx_d;

  always_comb begin
    sel_d   = '0;
    found_d = 1'b0;
    idx_d   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_d = (32'(ptr_q) + i) % N_REQ;
      if (!found_d && req[PTR_W'(idx_d)]) begin
        found_d = 1'b1;
        sel_d   = PTR_W'(idx_d);
      end
    end
  end

  // Operand mux follows the registered grant so it is stable from LAUNCH on.
  assign tree_data = req_data[32'(g_q) * VEC_W +: VEC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      wd_q         <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_sum_q    <= '0;
      tree_start_q <= 1'b0;
      tree_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Pulse-type outputs default to their inactive level every cycle.
      tree_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      tree_rst_n_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            g_q          <= sel_d;
            gnt_q        <= ONE_HOT0 << sel_d;
            tree_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last watchdog cycle still counts.
          if (tree_done) begin
            rsp_sum_q   <= tree_sum;
            rsp_valid_q <= ONE_HOT0 << g_q;
            state_q     <= RESP;
          end else if (wd_q == WD_LAST) begin
            err_q        <= 1'b1;
            rsp_sum_q    <= '0;
            tree_rst_n_q <= 1'b0;
            state_q      <= FLUSH;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        FLUSH: begin
          rsp_valid_q <= ONE_HOT0 << g_q;
          state_q     <= RESP;
        end
        RESP: begin
          ptr_q   <= PTR_W'((32'(g_q) + 1) % N_REQ);
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_sum     = rsp_sum_q;
  assign tree_start  = tree_start_q;
  assign tree_rst_n  = tree_rst_n_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_adder_tree_sched.sv
module tb_adder_tree_sched;

  localparam int WIDTH      = 5;
  localparam int INPUTS_NUM = 8;
  localparam int N_REQ      = 4;
  localparam int TIMEOUT    = 64;
  localparam int STAGES     = 3;
  localparam int SUM_W      = WIDTH + STAGES;
  localparam int VW         = INPUTS_NUM * WIDTH;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*VW-1:0]    req_data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [SUM_W-1:0]       rsp_sum;
  logic                   tree_start;
  logic [VW-1:0]          tree_data;
  logic [SUM_W-1:0]       tree_sum;
  logic                   tree_done;
  logic                   tree_rst_n;
  logic                   busy;
  logic                   err_timeout;

  adder_tree_sched #(
    .WIDTH(WIDTH),
    .INPUTS_NUM(INPUTS_NUM),
    .N_REQ(N_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum),
    .tree_start(tree_start),
    .tree_data(tree_data),
    .tree_sum(tree_sum),
    .tree_done(tree_done),
    .tree_rst_n(tree_rst_n),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder tree: samples start, spends STAGES cycles computing,
  // then presents done for one cycle. 'hang' suppresses done.
  logic             hang;
  logic             m_busy = 1'b0;
  int               m_cnt  = 0;
  logic [SUM_W-1:0] m_sum  = '0;

  function automatic logic [SUM_W-1:0] add_ops(input logic [VW-1:0] v);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < INPUTS_NUM; k++) s = s + SUM_W'(v[k*WIDTH +: WIDTH]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (tree_rst_n !== 1'b1) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (tree_done) m_busy <= 1'b0;
      else m_cnt <= m_cnt + 1;
    end else if (tree_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_sum  <= add_ops(tree_data);
    end
  end

  assign tree_done = m_busy && !hang && (m_cnt == STAGES + 1);
  assign tree_sum  = m_sum;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] ramp(input int s, input int d);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < INPUTS_NUM; k++) v[k*WIDTH +: WIDTH] = WIDTH'(s + k * d);
    return v;
  endfunction

  task automatic set_data(input int r, input logic [VW-1:0] v);
    req_data[r*VW +: VW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One transaction from IDLE; called and returns on a falling edge.
  task automatic txn(input logic [N_REQ-1:0] r, input int exp_g, input int exp_sum,
                     input int exp_lat, input int drop_at, input int exp_rstn_low);
    int  lat, starts, rstn_low, gnt_bad;
    bit  seen;
    lat = 0; starts = 0; rstn_low = 0; gnt_bad = 0; seen = 0;
    req = r;
    for (int k = 1; k <= exp_lat + 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("launch_gnt", 64'(gnt), 64'(1 << exp_g));
        check("launch_start", 64'(tree_start), 64'(1));
        check("launch_busy", 64'(busy), 64'(1));
      end
      if (tree_start) starts++;
      if (!tree_rst_n) rstn_low++;
      if (gnt !== N_REQ'(1 << exp_g)) gnt_bad++;
      if (k == drop_at) req = '0;
      if (rsp_valid != '0) begin
        seen = 1;
        lat  = k;
        check("rsp_valid", 64'(rsp_valid), 64'(1 << exp_g));
        check("rsp_sum", 64'(rsp_sum), 64'(exp_sum));
        req = '0;
      end
    end
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("start_pulses", 64'(starts), 64'(1));
    check("flush_cycles", 64'(rstn_low), 64'(exp_rstn_low));
    check("gnt_hold", 64'(gnt_bad), 64'(0));
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_gnt", 64'(gnt), 64'(0));
    check("idle_valid", 64'(rsp_valid), 64'(0));
  endtask

  int exp_sums [N_REQ];

  // Several requesters; order packs 2-bit requester ids, entry 0 in bits [1:0].
  task automatic run_multi(input logic [N_REQ-1:0] pat, input bit persist,
                           input int n, input logic [15:0] order);
    int cyc, last, idx, got_n;
    cyc = 0; last = 0; got_n = 0;
    req = pat;
    while (got_n < n && cyc < 20 * n) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != '0) begin
        idx = int'(order[got_n*2 +: 2]);
        check("rr_order", 64'(rsp_valid), 64'(1 << idx));
        check("rr_sum", 64'(rsp_sum), 64'(exp_sums[idx]));
        if (got_n == 0) check("rr_first_lat", 64'(cyc), 64'(6));
        else check("rr_gap", 64'(cyc - last), 64'(7));
        last = cyc;
        got_n++;
        if (got_n == n) req = '0;
        else if (!persist) req = req & ~rsp_valid;
      end
    end
    check("rr_count", 64'(got_n), 64'(n));
    @(negedge clk);
    check("rr_idle", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [N_REQ-1:0] req;
    int               g;
    int               start;
    int               step;
    int               sum;
  } vec_t;

  vec_t vt [5];

  initial begin
    int quiet_bad;

    vt[0] = '{req: 4'b0001, g: 0, start: 1,  step: 1, sum: 36};
    vt[1] = '{req: 4'b0100, g: 2, start: 31, step: 0, sum: 248};
    vt[2] = '{req: 4'b1000, g: 3, start: 0,  step: 1, sum: 28};
    vt[3] = '{req: 4'b0010, g: 1, start: 2,  step: 3, sum: 100};
    vt[4] = '{req: 4'b0001, g: 0, start: 3,  step: 2, sum: 80};

    hang     = 1'b0;
    req      = '0;
    req_data = '0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_sum", 64'(rsp_sum), 64'(0));
    check("rst_start", 64'(tree_start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    check("rst_tree_rst_n", 64'(tree_rst_n), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tree_rst_n", 64'(tree_rst_n), 64'(1));

    for (int i = 0; i < 5; i++) begin
      set_data(vt[i].g, ramp(vt[i].start, vt[i].step));
      txn(vt[i].req, vt[i].g, vt[i].sum, STAGES + 3, 0, 0);
    end

    set_data(0, ramp(1, 1));
    set_data(1, ramp(2, 3));
    set_data(2, ramp(31, 0));
    set_data(3, ramp(0, 1));
    exp_sums[0] = 36; exp_sums[1] = 100; exp_sums[2] = 248; exp_sums[3] = 28;
    do_reset();
    run_multi(4'b1010, 1'b0, 2, 16'h000D);
    run_multi(4'b1111, 1'b1, 5, 16'h00E4);

    set_data(2, ramp(4, 1));
    txn(4'b0100, 2, 60, STAGES + 3, 3, 0);

    // Reset while the tree is busy: the result is discarded.
    req = 4'b0001;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("midrst_gnt", 64'(gnt), 64'(0));
    check("midrst_valid", 64'(rsp_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_start", 64'(tree_start), 64'(0));
    check("midrst_tree_rst_n", 64'(tree_rst_n), 64'(0));
    rst = 1'b0;
    quiet_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) quiet_bad++;
    end
    check("midrst_quiet", 64'(quiet_bad), 64'(0));
    txn(4'b0001, 0, 36, STAGES + 3, 0, 0);

    hang = 1'b1;
    txn(4'b0010, 1, 0, TIMEOUT + 3, 0, 1);
    check("hang_err", 64'(err_timeout), 64'(1));
    hang = 1'b0;
    txn(4'b0100, 2, 60, STAGES + 3, 0, 0);
    check("err_sticky", 64'(err_timeout), 64'(1));
    do_reset();
    check("err_cleared", 64'(err_timeout), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
